// File: rtl/crop_filter.sv
`default_nettype none
// ============================================================================
//  Module      : crop_filter
//  Description : Streaming region-of-interest cropper. Consumes a raster
//                frame of IN_ROWS x IN_COLS pixels and forwards only the
//                OUT_ROWS x OUT_COLS window at (Y_1, X_1), in raster order,
//                through a single registered valid/ready output stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module crop_filter #(
    parameter int PIXEL_BIT_WIDTH = 16,
    parameter int IN_ROWS         = 100,
    parameter int IN_COLS         = 160,
    parameter int OUT_ROWS        = 48,
    parameter int OUT_COLS        = 48,
    parameter int Y_1             = 10,
    parameter int X_1             = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [PIXEL_BIT_WIDTH-1:0] pixel_out,
    output logic                       out_valid,
    input  logic                       out_ready
);

    // Counter widths cover 0..IN_x-1; a one-pixel dimension still gets one bit.
    localparam int c_row_w = (IN_ROWS > 1) ? $clog2(IN_ROWS) : 1;
    localparam int c_col_w = (IN_COLS > 1) ? $clog2(IN_COLS) : 1;

    // Window bounds are kept inclusive so every constant fits the counter width,
    // even when the window touches the last row/column of the frame.
    localparam logic [c_row_w-1:0] c_row_last      = c_row_w'(IN_ROWS - 1);
    localparam logic [c_col_w-1:0] c_col_last      = c_col_w'(IN_COLS - 1);
    localparam logic [c_row_w-1:0] c_win_row_first = c_row_w'(Y_1);
    localparam logic [c_row_w-1:0] c_win_row_last  = c_row_w'(Y_1 + OUT_ROWS - 1);
    localparam logic [c_col_w-1:0] c_win_col_first = c_col_w'(X_1);
    localparam logic [c_col_w-1:0] c_win_col_last  = c_col_w'(X_1 + OUT_COLS - 1);

    // Reject parameter sets whose window does not lie inside the frame.
    generate
        if ((PIXEL_BIT_WIDTH < 1) || (IN_ROWS < 1) || (IN_COLS < 1) ||
            (OUT_ROWS < 1) || (OUT_COLS < 1) || (Y_1 < 0) || (X_1 < 0) ||
            (Y_1 + OUT_ROWS > IN_ROWS) || (X_1 + OUT_COLS > IN_COLS)) begin : g_bad_params
            $error("crop_filter: illegal size or window outside input frame");
        end
    endgenerate

    logic [c_row_w-1:0]         row_q, row_d;
    logic [c_col_w-1:0]         col_q, col_d;
    logic [PIXEL_BIT_WIDTH-1:0] pixel_out_q, pixel_out_d;
    logic                       out_valid_q, out_valid_d;
    logic                       w_accept;
    logic                       w_in_window;

    // The output register can take a new pixel whenever it is empty or draining.
    assign in_ready  = ~out_valid_q | out_ready;
    assign pixel_out = pixel_out_q;
    assign out_valid = out_valid_q;

    // Raster position tracking: advance on every accepted pixel, wrap per row and frame.
    always_comb begin
        w_accept = in_valid & in_ready;
        row_d    = row_q;
        col_d    = col_q;
        if (w_accept) begin
            if (col_q == c_col_last) begin
                col_d = '0;
                if (row_q == c_row_last) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + c_row_w'(1);
                end
            end else begin
                col_d = col_q + c_col_w'(1);
            end
        end
    end

    // Output stage: load window pixels, clear valid once the sink has taken the data.
    always_comb begin
        w_in_window = (row_q >= c_win_row_first) && (row_q <= c_win_row_last) &&
                      (col_q >= c_win_col_first) && (col_q <= c_win_col_last);
        pixel_out_d = pixel_out_q;
        out_valid_d = out_valid_q;
        if (w_accept && w_in_window) begin
            pixel_out_d = pixel_in;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset discards any partial frame immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_q       <= '0;
            col_q       <= '0;
            pixel_out_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            row_q       <= row_d;
            col_q       <= col_d;
            pixel_out_q <= pixel_out_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_crop_filter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_crop_filter
//  Description : Self-checking bench for crop_filter. Raster-index frames are
//                streamed in; a scoreboard queue holds the expected window
//                pixels and is popped on every output handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_crop_filter;

    localparam int c_pw    = 16;
    localparam int c_frame = 100 * 160;

    typedef struct packed {
        logic [8*12-1:0] name;
        int              vprob;
        int              rprob;
        int              frames;
        int              exp_cnt;
        int              exp_first;
        int              exp_last;
    } vec_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [c_pw-1:0] pixel_in;
    logic            in_valid;
    logic            in_ready;
    logic [c_pw-1:0] pixel_out;
    logic            out_valid;
    logic            out_ready;

    logic [c_pw-1:0] c_pixel_in;
    logic            c_in_valid;
    logic            c_in_ready;
    logic [c_pw-1:0] c_pixel_out;
    logic            c_out_valid;
    logic            c_out_ready;

    int tests = 0;
    int fails = 0;

    int idx;
    int out_cnt;
    int first_out;
    int last_out;
    int second_first;
    bit prev_win;
    bit full_mode;
    int sb_q[$];

    crop_filter dut (
        .clk       (clk),
        .reset     (reset),
        .pixel_in  (pixel_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pixel_out (pixel_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    crop_filter #(
        .PIXEL_BIT_WIDTH (c_pw),
        .IN_ROWS         (4),
        .IN_COLS         (4),
        .OUT_ROWS        (2),
        .OUT_COLS        (2),
        .Y_1             (2),
        .X_1             (2)
    ) dut_c (
        .clk       (clk),
        .reset     (reset),
        .pixel_in  (c_pixel_in),
        .in_valid  (c_in_valid),
        .in_ready  (c_in_ready),
        .pixel_out (c_pixel_out),
        .out_valid (c_out_valid),
        .out_ready (c_out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %0s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit in_win(input int i);
        int r;
        int c;
        r = i / 160;
        c = i % 160;
        return (r >= 10) && (r < 58) && (c >= 10) && (c < 58);
    endfunction

    // One clock: drive at negedge, sample handshakes 1 ns later, then wait for posedge.
    task automatic step(input bit v, input bit r);
        int loc;
        bit w;
        @(negedge clk);
        loc       = idx % c_frame;
        in_valid  = v;
        out_ready = r;
        pixel_in  = v ? c_pw'(loc) : c_pw'($urandom);
        #1;
        if (out_valid && out_ready) begin
            out_cnt++;
            if (sb_q.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                check("sb_data", int'(pixel_out), sb_q.pop_front());
            end
            if (out_cnt == 1) first_out = int'(pixel_out);
            if (out_cnt == 2305) second_first = int'(pixel_out);
            last_out = int'(pixel_out);
        end
        if (full_mode) begin
            check("latency_valid", int'(out_valid), int'(prev_win));
            check("full_in_ready", int'(in_ready), 1);
        end
        if (in_valid && in_ready) begin
            w = in_win(loc);
            if (w) sb_q.push_back(loc);
            prev_win = w;
            idx++;
        end else begin
            prev_win = 1'b0;
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        c_in_valid  = 1'b0;
        c_out_ready = 1'b0;
        c_pixel_in  = '0;
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_pixel_out", int'(pixel_out), 0);
        check("rst_in_ready", int'(in_ready), 1);
        sb_q.delete();
        idx          = 0;
        out_cnt      = 0;
        first_out    = -1;
        last_out     = -1;
        second_first = -1;
        prev_win     = 1'b0;
        full_mode    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    vec_t vecs[3];
    int   c_got[$];
    int   c_exp[4];
    int   c_idx;
    int   cyc;

    initial begin
        vecs[0] = '{"random",     70,  60,  1, 2304, 1610, 9177};
        vecs[1] = '{"slow_sink",  100, 40,  1, 2304, 1610, 9177};
        vecs[2] = '{"full_2frm",  100, 100, 2, 4608, 1610, 9177};
        c_exp   = '{10, 11, 14, 15};
        pixel_in = '0;

        // Table-driven whole-frame runs through the scoreboard.
        for (int v = 0; v < 3; v++) begin
            do_reset();
            full_mode = (vecs[v].vprob == 100) && (vecs[v].rprob == 100);
            cyc = 0;
            while ((idx < vecs[v].frames * c_frame) && (cyc < 45000 * vecs[v].frames)) begin
                step(($urandom_range(99) < vecs[v].vprob), ($urandom_range(99) < vecs[v].rprob));
                cyc++;
            end
            check("timeout", int'(cyc >= 45000 * vecs[v].frames), 0);
            repeat (4) step(1'b0, 1'b1);
            check("out_count", out_cnt, vecs[v].exp_cnt);
            check("first_out", first_out, vecs[v].exp_first);
            check("last_out", last_out, vecs[v].exp_last);
            check("sb_empty", sb_q.size(), 0);
            if (vecs[v].frames == 2) check("frame2_first", second_first, 1610);
        end

        // Back-pressure hold on the first window pixel.
        do_reset();
        cyc = 0;
        while ((idx < 1611) && (cyc < 3000)) begin
            step(1'b1, 1'b1);
            cyc++;
        end
        check("hold_reach", idx, 1611);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0);
            #2;
            check("hold_valid", int'(out_valid), 1);
            check("hold_pixel", int'(pixel_out), 1610);
            check("hold_in_ready", int'(in_ready), 0);
            check("hold_no_accept", idx, 1611);
        end
        step(1'b1, 1'b1);
        check("release_cnt", out_cnt, 1);
        check("release_first", first_out, 1610);
        step(1'b1, 1'b1);
        check("resume_cnt", out_cnt, 2);
        check("resume_pixel", last_out, 1611);

        // Asynchronous reset in the middle of a frame, then a fresh frame.
        do_reset();
        full_mode = 1'b1;
        cyc = 0;
        while ((idx < 5000) && (cyc < 6000)) begin
            step(1'b1, 1'b1);
            cyc++;
        end
        #2;
        check("pre_reset_valid", int'(out_valid), 1);
        check("pre_reset_pixel", int'(pixel_out), 4999);
        do_reset();
        full_mode = 1'b1;
        cyc = 0;
        while ((out_cnt < 1) && (cyc < 2000)) begin
            step(1'b1, 1'b1);
            cyc++;
        end
        check("post_reset_first", first_out, 1610);

        // Small corner parameter set: 4x4 frame, 2x2 window at (2,2).
        do_reset();
        c_idx = 0;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            c_in_valid  = (c_idx < 16);
            c_pixel_in  = c_pw'(c_idx);
            c_out_ready = (i % 3) != 1;
            #1;
            if (c_out_valid && c_out_ready) c_got.push_back(int'(c_pixel_out));
            if (c_in_valid && c_in_ready) c_idx++;
            @(posedge clk);
        end
        check("corner_count", c_got.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("corner_pixel", (i < c_got.size()) ? c_got[i] : -1, c_exp[i]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
